// File: rtl/inst_mem_sync_if.sv
// inst_mem_sync_if: fetch, status and load-port bundle for inst_mem_sync.
// INST_MEM_PARITY_EN adds wr_par_inv and parity_err.
interface inst_mem_sync_if #(
  parameter int INST_W = 64,
  parameter int ADDR_W = 32
);
  logic              ce;
  logic              req;
  logic              stall;
  logic [ADDR_W-1:0] addr;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              addr_err;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_data;
  logic              wr_ack;
`ifdef INST_MEM_PARITY_EN
  logic              wr_par_inv;
  logic              parity_err;

  modport master (
    output ce, req, stall, addr,
    output wr_en, wr_addr, wr_data, wr_par_inv,
    input  inst, inst_valid, addr_err, ready,
    input  wr_ack, parity_err
  );

  modport slave (
    input  ce, req, stall, addr,
    input  wr_en, wr_addr, wr_data, wr_par_inv,
    output inst, inst_valid, addr_err, ready,
    output wr_ack, parity_err
  );
`else
  modport master (
    output ce, req, stall, addr,
    output wr_en, wr_addr, wr_data,
    input  inst, inst_valid, addr_err, ready,
    input  wr_ack
  );

  modport slave (
    input  ce, req, stall, addr,
    input  wr_en, wr_addr, wr_data,
    output inst, inst_valid, addr_err, ready,
    output wr_ack
  );
`endif
endinterface

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: synchronous instruction memory, boot zero-fill, 1-cycle
// registered fetch, load port. Optional per-word parity: INST_MEM_PARITY_EN.
module inst_mem_sync #(
  parameter int INST_W   = 64,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int ADDR_LSB = 3
) (
  input logic            clk,
  input logic            rst,
  inst_mem_sync_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI    = ADDR_LSB + IDX_W;
`ifdef INST_MEM_PARITY_EN
  localparam int WORD_W = INST_W + 1;
`else
  localparam int WORD_W = INST_W;
`endif
  localparam logic [ADDR_W-1:0] LO_MASK =
    ADDR_W'((64'd1 << ADDR_LSB) - 64'd1);
  localparam logic [ADDR_W-1:0] HI_MASK =
    ~ADDR_W'((64'd1 << HI) - 64'd1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              ack_q, ack_d;
`ifdef INST_MEM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [WORD_W-1:0] mem_wd;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_bad;
  logic              wr_ok;
  logic [WORD_W-1:0] rd_word;

  assign rd_idx  = bus.addr[ADDR_LSB +: IDX_W];
  assign wr_idx  = bus.wr_addr[ADDR_LSB +: IDX_W];
  assign rd_bad  = |(bus.addr & (LO_MASK | HI_MASK));
  assign wr_ok   = ~|(bus.wr_addr & (LO_MASK | HI_MASK));
  assign rd_word = mem_q[rd_idx];

  // Next state: boot fill, fetch output priority and load-port write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    err_d   = err_q;
    ack_d   = 1'b0;
`ifdef INST_MEM_PARITY_EN
    perr_d  = perr_q;
`endif
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = '0;
    if (state_q == BOOT) begin
      mem_we  = ~rst;
      cnt_d   = cnt_q + 1'b1;
      inst_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
`ifdef INST_MEM_PARITY_EN
      perr_d  = 1'b0;
`endif
      if (cnt_q == LAST) state_d = RUN;
    end else begin
      if (!bus.ce) begin
        inst_d  = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef INST_MEM_PARITY_EN
        perr_d  = 1'b0;
`endif
      end else if (bus.stall) begin
        inst_d  = inst_q;
      end else if (!bus.req) begin
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef INST_MEM_PARITY_EN
        perr_d  = 1'b0;
`endif
      end else begin
        valid_d = 1'b0 | 1'b1;
        err_d   = rd_bad;
        inst_d  = rd_bad ? '0 : rd_word[INST_W-1:0];
`ifdef INST_MEM_PARITY_EN
        perr_d  = ~rd_bad &
                  ((^rd_word[INST_W-1:0]) != rd_word[INST_W]);
`endif
      end
      if (bus.wr_en && wr_ok && !rst) begin
        mem_we = 1'b1;
        mem_wa = wr_idx;
        ack_d  = 1'b1;
`ifdef INST_MEM_PARITY_EN
        mem_wd = {(^bus.wr_data) ^ bus.wr_par_inv, bus.wr_data};
`else
        mem_wd = bus.wr_data;
`endif
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
`ifdef INST_MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Storage array; reads above see the pre-edge word (read-first).
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.addr_err   = err_q;
  assign bus.ready      = (state_q == RUN);
  assign bus.wr_ack     = ack_q;
`ifdef INST_MEM_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule
